// File: rtl/c499_seq_ctrl_pkg.sv
// Shared constants and types for the c499 sequencer: widths, FSM states and
// the settle-counter helper.
package c499_ctrl_pkg;

  localparam int KEY_W = 16;
  localparam int IN_W  = 41;
  localparam int OUT_W = 32;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // Initial settle-counter value: the count runs down to zero, so load cycles-1.
  function automatic logic [CNT_W-1:0] settle_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/c499_seq_ctrl_if.sv
// Input and output valid/ready channels between the host and the c499 sequencer.
interface c499_seq_ctrl_if #(
  parameter int IN_W  = 41,
  parameter int OUT_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/c499_key_loader.sv
// Serial key shadow, staged commit and deferred application of the unlock key.
// core_key changes only when the sequencer raises apply.
module c499_key_loader
  import c499_ctrl_pkg::*;
#(
  parameter int W = KEY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_bit,
  input  logic         key_shift,
  input  logic         key_commit,
  input  logic         apply,
  output logic         pending,
  output logic         key_loaded,
  output logic [W-1:0] core_key
);

  logic [W-1:0] r_shadow;
  logic [W-1:0] r_stage;
  logic [W-1:0] r_core_key;
  logic         r_pending;
  logic         r_key_loaded;
  logic [W-1:0] w_shadow_next;

  // A commit in the same cycle as a shift must see the newly shifted bit.
  assign w_shadow_next = key_shift ? {r_shadow[W-2:0], key_bit} : r_shadow;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register reads the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow     <= '0;
      r_stage      <= '0;
      r_core_key   <= '0;
      r_pending    <= 1'b0;
      r_key_loaded <= 1'b0;
    end else begin
      r_shadow <= w_shadow_next;
      if (key_commit) begin
        r_stage   <= w_shadow_next;
        r_pending <= 1'b1;
      end else if (apply) begin
        r_pending <= 1'b0;
      end
      if (apply) begin
        r_core_key   <= r_stage;
        r_key_loaded <= 1'b1;
      end
    end
  end

  assign pending    = r_pending;
  assign key_loaded = r_key_loaded;
  assign core_key   = r_core_key;

endmodule

// File: rtl/c499_seq_ctrl.sv
// Sequencer for the key-locked c499 core: accepts a vector, drives the core,
// waits SETTLE_CYCLES and returns the captured result over valid/ready.
module c499_seq_ctrl
  import c499_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int P_KEY_W       = KEY_W,
  parameter int P_IN_W        = IN_W,
  parameter int P_OUT_W       = OUT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_bit,
  input  logic               key_shift,
  input  logic               key_commit,
  output logic               key_loaded,
  c499_seq_ctrl_if.slave     bus,
  output logic [P_KEY_W-1:0] core_key,
  output logic [P_IN_W-1:0]  core_in,
  input  logic [P_OUT_W-1:0] core_out,
  output logic               busy,
  output logic [15:0]        op_count
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [P_IN_W-1:0]  r_core_in;
  logic [P_OUT_W-1:0] r_out_data;
  logic               r_out_valid;
  logic [15:0]        r_op_count;

  logic w_pending;
  logic w_apply;
  logic w_accept;

  // Key application owns the IDLE cycle it happens in, so no accept then.
  assign w_apply  = (r_state == ST_IDLE) && w_pending;
  assign w_accept = bus.in_valid && bus.in_ready;

  c499_key_loader #(.W(P_KEY_W)) u_key_loader (
    .clk        (clk),
    .rst        (rst),
    .key_bit    (key_bit),
    .key_shift  (key_shift),
    .key_commit (key_commit),
    .apply      (w_apply),
    .pending    (w_pending),
    .key_loaded (key_loaded),
    .core_key   (core_key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_core_in   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_op_count  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_core_in <= bus.in_data;
            r_cnt     <= settle_load(SETTLE_CYCLES);
            r_state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_out_data  <= core_out;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // in_ready is forced low during reset because the reset state alone is IDLE.
  assign bus.in_ready  = !rst && (r_state == ST_IDLE) && !w_pending;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign core_in       = r_core_in;
  assign busy          = (r_state != ST_IDLE) || w_pending;
  assign op_count      = r_op_count;

endmodule

// File: tb/tb_c499_seq_ctrl.sv
// Directed bench for c499_seq_ctrl with a pass-through stub core whose output
// can be perturbed to prove the result is captured, not tracked.
module tb_c499_seq_ctrl;
  import c499_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             key_bit = 1'b0;
  logic             key_shift = 1'b0;
  logic             key_commit = 1'b0;
  logic             key_loaded;
  logic [KEY_W-1:0] core_key;
  logic [IN_W-1:0]  core_in;
  logic [OUT_W-1:0] core_out;
  logic             busy;
  logic [15:0]      op_count;
  logic [OUT_W-1:0] tweak = '0;

  int n_checks = 0;
  int n_errors = 0;

  c499_seq_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  c499_seq_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_bit    (key_bit),
    .key_shift  (key_shift),
    .key_commit (key_commit),
    .key_loaded (key_loaded),
    .bus        (bus.slave),
    .core_key   (core_key),
    .core_in    (core_in),
    .core_out   (core_out),
    .busy       (busy),
    .op_count   (op_count)
  );

  assign core_out = core_in[OUT_W-1:0] ^ tweak;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_key(input logic [15:0] k);
    for (int i = 15; i >= 0; i--) begin
      key_bit   = k[i];
      key_shift = 1'b1;
      step();
    end
    key_shift = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Power-on reset
    repeat (3) step();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_core_key", 64'(core_key), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Key load 0x795E, commit while IDLE
    shift_key(16'h795E);
    check("key_no_direct", 64'(core_key), 64'd0);
    key_commit = 1'b1;
    step();
    key_commit = 1'b0;
    check("commit_in_ready_low", 64'(bus.in_ready), 64'd0);
    check("commit_busy", 64'(busy), 64'd1);
    step();
    check("apply_core_key", 64'(core_key), 64'h795E);
    check("apply_key_loaded", 64'(key_loaded), 64'd1);
    check("apply_in_ready", 64'(bus.in_ready), 64'd1);

    // Latency and backpressure
    bus.in_valid = 1'b1;
    bus.in_data  = 41'h45678969;
    step();
    bus.in_valid = 1'b0;
    check("acc_core_in", 64'(core_in), 64'h45678969);
    check("acc_in_ready", 64'(bus.in_ready), 64'd0);
    check("lat1_out_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("lat2_out_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("lat_out_valid", 64'(bus.out_valid), 64'd1);
    check("lat_out_data", 64'(bus.out_data), 64'h45678969);
    tweak = 32'hDEAD_0000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_out_data", 64'(bus.out_data), 64'h45678969);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    check("bp_op_count", 64'(op_count), 64'd0);
    tweak = '0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("hs_out_valid", 64'(bus.out_valid), 64'd0);
    check("hs_op_count", 64'(op_count), 64'd1);
    check("hs_in_ready", 64'(bus.in_ready), 64'd1);

    // Commit 0xFFFF during SETTLE
    shift_key(16'hFFFF);
    bus.in_valid = 1'b1;
    bus.in_data  = 41'h1_0000_1234;
    step();
    bus.in_valid = 1'b0;
    key_commit   = 1'b1;
    step();
    key_commit = 1'b0;
    check("mid_core_key_settle", 64'(core_key), 64'h795E);
    step();
    check("mid_out_valid", 64'(bus.out_valid), 64'd1);
    check("mid_out_data", 64'(bus.out_data), 64'h1234);
    check("mid_core_key_hold", 64'(core_key), 64'h795E);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("mid_hs_op_count", 64'(op_count), 64'd2);
    check("mid_hs_core_key", 64'(core_key), 64'h795E);
    check("mid_hs_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    check("mid_apply_core_key", 64'(core_key), 64'hFFFF);
    check("mid_apply_in_ready", 64'(bus.in_ready), 64'd1);

    // op_count wrap, out_ready held high before out_valid
    force dut.r_op_count = 16'hFFFF;
    #1;
    release dut.r_op_count;
    check("wrap_preload", 64'(op_count), 64'hFFFF);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 41'h0AB_CDEF_0123;
    step();
    bus.in_valid = 1'b0;
    step();
    check("early_ready_out_valid", 64'(bus.out_valid), 64'd0);
    check("early_ready_op_count", 64'(op_count), 64'hFFFF);
    step();
    check("wrap_out_data", 64'(bus.out_data), 64'hCDEF_0123);
    step();
    bus.out_ready = 1'b0;
    check("wrap_out_valid", 64'(bus.out_valid), 64'd0);
    check("wrap_op_count", 64'(op_count), 64'd0);

    // Reset in the middle of a transaction
    bus.in_valid = 1'b1;
    bus.in_data  = 41'h1FF_FFFF_FFFF;
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    end
    check("mrst_out_data", 64'(bus.out_data), 64'd0);
    check("mrst_core_in", 64'(core_in), 64'd0);
    check("mrst_core_key", 64'(core_key), 64'd0);
    check("mrst_key_loaded", 64'(key_loaded), 64'd0);
    check("mrst_op_count", 64'(op_count), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    step();
    check("mrst_release_in_ready", 64'(bus.in_ready), 64'd1);
    check("mrst_release_out_valid", 64'(bus.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
